ob_mc_ingress: RTL
==================

// Module: ob_mc_ingress
//
// PURPOSE
// - Multi-channel command ingress for the order-book core; generalises the single ingress queue to CH_N independent sources.
// - Each channel has its own command FIFO and registered full flag.
// - An arbiter (round-robin or fixed-priority) merges the channel FIFO heads into one command stream for ob_cntrl.
// - Every command carries its source channel id so responses can be routed back.
//
// PARAMETERS
// - CH_N      4                        number of command channels (1..16)
// - DEPTH     4                        entries per channel FIFO (power of 2, >=2)
// - CMD_W     $bits(ob_pkg::cmd_t)     command payload width
// - ARB_MODE  ob_pkg::ARB_RR           ARB_RR = round-robin; ARB_FIXED = lowest index wins
//
// PORTS
// - clk        in   1              clock, all state on rising edge
// - rst_n      in   1              reset, asynchronous, active-low
// - in_vld     in   CH_N           per-channel push strobe
// - in_cmd     in   CH_N*CMD_W     per-channel command; channel c at [c*CMD_W +: CMD_W]
// - in_full_r  out  CH_N           registered per-channel FIFO full
// - out_vld    out  1              a granted command is presented
// - out_cmd    out  CMD_W          granted command (head of granted FIFO)
// - out_ch     out  CH_W           granted channel id; CH_W = max(1, $clog2(CH_N))
// - out_pop    in   1              consumer accepts out_cmd this cycle (legal only with out_vld)
// - err_ovf_r  out  CH_N           sticky overflow: push attempted while full and not popping
//
// BEHAVIOUR
// - Reset values: FIFOs empty, in_full_r = 0, out_vld = 0, out_ch = 0, rr_ptr = 0, lock = 0, err_ovf_r = 0.
// - out_cmd is don't-care while out_vld = 0.
// - Push accept rule: push accepted iff in_vld[c] && (cnt[c] < DEPTH || pop of channel c this cycle).
//   - A rejected push is dropped and sets err_ovf_r[c]; only rst_n clears it.
// - in_full_r[c] = (next cnt[c] == DEPTH), registered.
//   - A push and a pop on the same channel in the same cycle leave the count unchanged.
// - Latency: a push into an empty FIFO is visible at out_vld on the next cycle; there is no bypass path.
// - out_vld = lock_r || (|non_empty).
// - Grant selection (when lock_r = 0):
//   - ARB_RR: first non-empty channel at or after rr_ptr, wrapping at CH_N-1 -> 0.
//   - ARB_FIXED: lowest-index non-empty channel.
// - Stability: if out_vld && !out_pop, set lock_r and hold the grant channel in grant_r.
//   - out_cmd and out_ch must not change until the pop.
//   - A newly non-empty, higher-priority channel does not preempt.
// - On out_pop:
//   - Pop the granted FIFO head and clear lock_r.
//   - ARB_RR only: rr_ptr <= (grant == CH_N-1) ? 0 : grant + 1.
//   - The next grant is evaluated combinationally in the following cycle.
//   - Back-to-back pops are supported: one command per cycle.
// - out_pop while out_vld = 0 is ignored (assertion in simulation).
// - FIFO pointers are DEPTH-modulo counters with wrap; the count is $clog2(DEPTH)+1 bits.
// - Reset mid-operation: all contents are discarded, outputs return to reset values immediately (async), and channel order restarts at rr_ptr = 0.
//
// STRUCTURE
// - ob_pkg additions:
//   - arb_mode_t enum {ARB_RR, ARB_FIXED}
//   - OB_CH_N_MAX = 16
//   - ch_id_t (logic [3:0])
// - Sub-module ob_mc_fifo (one per channel via generate):
//   - Ports: push/push_data, pop/pop_data, cnt, full_r, empty; async active-low reset.
// - Top level holds: arbiter, lock/grant_r, rr_ptr, overflow flags, and the payload mux.
// - No other sub-modules.
//
// TESTING
// - Reset: rst_n low for 3 cycles with in_vld = 4'hF.
//   -> in_full_r = 0, out_vld = 0, err_ovf_r = 0; nothing enqueued.
// - RR fairness, CH_N = 4, ARB_RR: push 2 commands on each channel in one burst, out_pop held at 1.
//   -> out_ch sequence 0,1,2,3,0,1,2,3; out_vld drops in the cycle after the 8th pop.
// - Fixed priority, ARB_FIXED: ch3 has 2 entries; ch0 is pushed 1 cycle later; out_pop = 1 throughout.
//   -> out_ch 3,0,3.
// - Grant hold: ch2 is presented with out_pop = 0 for 5 cycles while ch0 fills.
//   -> out_ch stays 2 and out_cmd is unchanged; after the pop, out_ch = 0 (ARB_FIXED) or 3 (ARB_RR if ch3 is non-empty).
// - Full / overflow, DEPTH = 4: push ch1 four times with no pop.
//   -> in_full_r[1] = 1 the cycle after the 4th push.
//   -> A 5th push sets err_ovf_r[1] = 1 and the FIFO still holds the first 4.
//   -> A push with a simultaneous pop on ch1 is accepted and full stays 1.
// - Wrap: 10 push/pop cycles on ch0, payloads 0..9.
//   -> out_cmd matches the push order across pointer wrap; the count never exceeds 1.
// - Async reset mid-stream: deassert rst_n between edges with 3 entries queued.
//   -> out_vld = 0 immediately; after release, the first new push is seen the next cycle.

Source files
------------

// File: rtl/ob_pkg.sv
// Shared order-book types: command payload, channel id and ingress arbitration mode.
// CH_W helper keeps channel-id ports at least one bit wide for single-channel builds.
package ob_pkg;

   localparam int OB_CH_N_MAX = 16;

   typedef logic [3:0] ch_id_t;

   typedef enum logic {
      ARB_RR,
      ARB_FIXED
   } arb_mode_t;

   typedef enum logic [1:0] {
      OP_NOP,
      OP_ADD,
      OP_CANCEL,
      OP_MODIFY
   } op_t;

   typedef struct packed {
      op_t        op;
      logic       side;
      logic [7:0] order_id;
      logic [11:0] price;
      logic [8:0] qty;
   } cmd_t;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ob_mc_fifo.sv
// Per-channel command FIFO; the caller guarantees push is never raised when full without a pop.
// Pointers wrap naturally at DEPTH (power of 2); the count is one bit wider than the pointers.
module ob_mc_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           pop_data,
   output logic [$clog2(DEPTH):0] cnt,
   output logic                   full_r,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt_r;
      case ({push, pop})
         2'b10:   cnt_nxt = cnt_r + 1'b1;
         2'b01:   cnt_nxt = cnt_r - 1'b1;
         default: cnt_nxt = cnt_r;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_r  <= '0;
         full_r <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         cnt_r  <= cnt_nxt;
         full_r <= (cnt_nxt == CW'(DEPTH));
      end
   end

   // Storage is left unreset: contents are only observable behind a non-zero count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
   assign cnt      = cnt_r;
   assign empty    = (cnt_r == '0);

endmodule

// File: rtl/ob_mc_ingress.sv
// Multi-channel command ingress: one FIFO per channel merged by a round-robin or fixed-priority
// arbiter; a presented grant is locked until popped so out_cmd/out_ch stay stable.
module ob_mc_ingress
   import ob_pkg::*;
#(
   parameter int        CH_N     = 4,
   parameter int        DEPTH    = 4,
   parameter int        CMD_W    = $bits(ob_pkg::cmd_t),
   parameter arb_mode_t ARB_MODE = ARB_RR
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [CH_N-1:0]         in_vld,
   input  logic [CH_N*CMD_W-1:0]   in_cmd,
   output logic [CH_N-1:0]         in_full_r,
   output logic                    out_vld,
   output logic [CMD_W-1:0]        out_cmd,
   output logic [ch_w(CH_N)-1:0]   out_ch,
   input  logic                    out_pop,
   output logic [CH_N-1:0]         err_ovf_r
);

   localparam int                CH_W    = ch_w(CH_N);
   localparam int                CW      = $clog2(DEPTH) + 1;
   localparam logic [CH_W-1:0]   LAST_CH = CH_W'(CH_N - 1);

   logic [CW-1:0]    cnt  [CH_N];
   logic [CMD_W-1:0] head [CH_N];
   logic [CH_N-1:0]  empty;
   logic [CH_N-1:0]  non_empty;
   logic [CH_N-1:0]  push_ok;
   logic [CH_N-1:0]  pop_ch;

   logic             lock_r;
   logic [CH_W-1:0]  grant_r;
   logic [CH_W-1:0]  rr_ptr;
   logic [CH_W-1:0]  sel;
   logic [CH_W-1:0]  scan;
   logic             found;
   logic [CH_W-1:0]  grant;
   logic             pop_fire;

   for (genvar c = 0; c < CH_N; c++) begin : g_ch
      assign pop_ch[c]  = pop_fire && (grant == CH_W'(c));
      // A full channel still accepts when its head leaves in the same cycle.
      assign push_ok[c] = in_vld[c] && ((cnt[c] < CW'(DEPTH)) || pop_ch[c]);

      ob_mc_fifo #(
         .DEPTH (DEPTH),
         .W     (CMD_W)
      ) u_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .push      (push_ok[c]),
         .push_data (in_cmd[c*CMD_W +: CMD_W]),
         .pop       (pop_ch[c]),
         .pop_data  (head[c]),
         .cnt       (cnt[c]),
         .full_r    (in_full_r[c]),
         .empty     (empty[c])
      );
   end

   assign non_empty = ~empty;

   always_comb begin
      sel   = '0;
      scan  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < CH_N; i++) begin
         if (ARB_MODE == ARB_RR) scan = CH_W'((32'(rr_ptr) + i) % 32'(CH_N));
         else                    scan = CH_W'(i);
         if (!found && non_empty[scan]) begin
            found = 1'b1;
            sel   = scan;
         end
      end
   end

   assign grant    = lock_r ? grant_r : sel;
   assign out_vld  = lock_r || (|non_empty);
   assign pop_fire = out_pop && out_vld;
   assign out_ch   = grant;
   assign out_cmd  = head[grant];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_r    <= 1'b0;
         grant_r   <= '0;
         rr_ptr    <= '0;
         err_ovf_r <= '0;
      end else begin
         err_ovf_r <= err_ovf_r | (in_vld & ~push_ok);
         if (pop_fire) begin
            lock_r <= 1'b0;
            if (ARB_MODE == ARB_RR) rr_ptr <= (grant == LAST_CH) ? '0 : grant + 1'b1;
         end else if (out_vld) begin
            lock_r  <= 1'b1;
            grant_r <= grant;
         end
      end
   end

   a_pop_needs_vld : assert property (@(posedge clk) disable iff (!rst_n) out_pop |-> out_vld);

endmodule
